mem_access_unit: RTL and testbench

- MEM-stage data-memory access unit.
- Takes load/store requests from the EX/MEM register and drives a request/acknowledge data-memory bus.
- Aligns and extends load data, including LWL/LWR partial loads.
- Produces the signals the MEM/WB register consumes: mem_data, reg_byte_w_en_in and mem_stall. mem_stall holds the pipeline while an access is outstanding.

---
 rtl/mem_access_unit.sv | 214 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: request/ack bus handshake, store lane steering, load alignment.
// Optional MEM_ADDR_EXC_EN: misaligned half/word accesses raise mem_addr_exc instead of being force-aligned.
module mem_access_unit #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exmem_mem_r,
  input  logic        exmem_mem_w,
  input  logic [2:0]  exmem_mem_op,
  input  logic [31:0] exmem_addr,
  input  logic [31:0] exmem_wdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] mem_data,
  output logic [3:0]  reg_byte_w_en_in,
  output logic        mem_bus_err
`ifdef MEM_ADDR_EXC_EN
  ,
  output logic        mem_addr_exc,
  output logic [31:0] mem_badvaddr
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam logic [9:0] WAIT_LAST = 10'(MAX_WAIT - 1);

  state_t      state;
  logic [9:0]  wait_cnt;
  logic        lat_load;
  logic [2:0]  lat_op;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic        access;
  logic        addr_exc;
  logic        cur_load;
  logic [2:0]  cur_op;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [1:0]  k;
  logic [31:0] cap_data;
  logic [3:0]  cap_en;

  function automatic logic [31:0] load_data(input logic [2:0] op, input logic [1:0] ofs,
                                            input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rdata >> {ofs, 3'b000});
    h = ofs[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      3'b010:  return rdata << {~ofs, 3'b000};
      3'b110:  return rdata >> {ofs, 3'b000};
      default: return rdata;
    endcase
  endfunction

  function automatic logic [3:0] load_en(input logic [2:0] op, input logic [1:0] ofs);
    case (op)
      3'b010:  return 4'(4'b1111 << ~ofs);
      3'b110:  return 4'b1111 >> ofs;
      default: return 4'b1111;
    endcase
  endfunction

  assign access = exmem_mem_r | exmem_mem_w;

  // While waiting the pipeline is frozen, but the bus is driven from the latched copy so it cannot glitch.
  always_comb begin
    cur_load  = exmem_mem_r;
    cur_op    = exmem_mem_op;
    cur_addr  = exmem_addr;
    cur_wdata = exmem_wdata;
    if (state == WAIT) begin
      cur_load  = lat_load;
      cur_op    = lat_op;
      cur_addr  = lat_addr;
      cur_wdata = lat_wdata;
    end
  end

  assign k = cur_addr[1:0];

`ifdef MEM_ADDR_EXC_EN
  logic is_half;
  logic is_word;
  assign is_half  = (exmem_mem_op[1:0] == 2'b01);
  assign is_word  = exmem_mem_r ? (exmem_mem_op[1:0] == 2'b11) : exmem_mem_op[1];
  assign addr_exc = (is_half & exmem_addr[0]) | (is_word & (exmem_addr[1:0] != 2'b00));
`else
  assign addr_exc = 1'b0;
`endif

  always_comb begin
    dmem_we    = ~cur_load;
    dmem_addr  = {cur_addr[31:2], 2'b00};
    dmem_be    = 4'b1111;
    dmem_wdata = cur_wdata;
    if (!cur_load) begin
      case (cur_op[1:0])
        2'b00: begin
          dmem_be    = 4'(4'b0001 << k);
          dmem_wdata = {4{cur_wdata[7:0]}};
        end
        2'b01: begin
          dmem_be    = k[1] ? 4'b1100 : 4'b0011;
          dmem_wdata = {2{cur_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Reset gates the request combinationally so an abandoned access drops off the bus at once.
  always_comb begin
    dmem_req  = 1'b0;
    mem_stall = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          mem_stall = access;
          dmem_req  = access & ~addr_exc;
        end
        WAIT: begin
          mem_stall = 1'b1;
          dmem_req  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A timeout is captured exactly like an ack whose read data is zero.
  always_comb begin
    cap_data = '0;
    cap_en   = '0;
    if (cur_load) begin
      cap_data = load_data(cur_op, k, dmem_ack ? dmem_rdata : 32'h0);
      cap_en   = load_en(cur_op, k);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      lat_load         <= 1'b0;
      lat_op           <= '0;
      lat_addr         <= '0;
      lat_wdata        <= '0;
      mem_data         <= '0;
      reg_byte_w_en_in <= '0;
      mem_bus_err      <= 1'b0;
`ifdef MEM_ADDR_EXC_EN
      mem_addr_exc     <= 1'b0;
      mem_badvaddr     <= '0;
`endif
    end else begin
      mem_bus_err  <= 1'b0;
`ifdef MEM_ADDR_EXC_EN
      mem_addr_exc <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (access) begin
            lat_load  <= exmem_mem_r;
            lat_op    <= exmem_mem_op;
            lat_addr  <= exmem_addr;
            lat_wdata <= exmem_wdata;
            if (addr_exc) begin
              state            <= DONE;
              mem_data         <= '0;
              reg_byte_w_en_in <= '0;
`ifdef MEM_ADDR_EXC_EN
              mem_addr_exc     <= 1'b1;
              mem_badvaddr     <= exmem_addr;
`endif
            end else if (dmem_ack) begin
              state            <= DONE;
              mem_data         <= cap_data;
              reg_byte_w_en_in <= cap_en;
            end else begin
              state    <= WAIT;
              wait_cnt <= '0;
            end
          end
        end
        WAIT: begin
          if (dmem_ack || wait_cnt == WAIT_LAST) begin
            state            <= DONE;
            mem_data         <= cap_data;
            reg_byte_w_en_in <= cap_en;
            mem_bus_err      <= ~dmem_ack;
          end else begin
            wait_cnt <= wait_cnt + 10'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a transaction-level reference model.
// Covers the MEM_ADDR_EXC_EN variant when the macro is defined at compile time.
module tb_mem_access_unit;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        exmem_mem_r, exmem_mem_w;
  logic [2:0]  exmem_mem_op;
  logic [31:0] exmem_addr, exmem_wdata;
  logic        dmem_req, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic [31:0] mem_data;
  logic [3:0]  reg_byte_w_en_in;
  logic        mem_bus_err;
`ifdef MEM_ADDR_EXC_EN
  logic        mem_addr_exc;
  logic [31:0] mem_badvaddr;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_data = '0;
  logic [3:0]  last_en = '0;
  bit          data_known = 1'b1;

  always #5 clk = ~clk;

  mem_access_unit #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .exmem_mem_r(exmem_mem_r), .exmem_mem_w(exmem_mem_w), .exmem_mem_op(exmem_mem_op),
    .exmem_addr(exmem_addr), .exmem_wdata(exmem_wdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .mem_data(mem_data),
    .reg_byte_w_en_in(reg_byte_w_en_in), .mem_bus_err(mem_bus_err)
`ifdef MEM_ADDR_EXC_EN
    , .mem_addr_exc(mem_addr_exc), .mem_badvaddr(mem_badvaddr)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: lane and alignment rules written as plain arithmetic.
  function automatic logic [31:0] expData(input logic [2:0] op, input int k, input logic [31:0] rdata);
    logic [31:0] b, h;
    b = (rdata >> (8 * k)) & 32'hFF;
    h = (rdata >> (16 * (k / 2))) & 32'hFFFF;
    case (op)
      3'd0:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      3'd2:    return rdata << (8 * (3 - k));
      3'd6:    return rdata >> (8 * k);
      default: return rdata;
    endcase
  endfunction

  function automatic logic [3:0] expLoadEn(input logic [2:0] op, input int k);
    logic [3:0] e;
    for (int i = 0; i < 4; i++) begin
      if (op == 3'd2)      e[i] = (i >= 3 - k);
      else if (op == 3'd6) e[i] = (i <= 3 - k);
      else                 e[i] = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [3:0] expStoreBe(input logic [2:0] op, input int k);
    logic [3:0] e;
    for (int i = 0; i < 4; i++) begin
      if (op == 3'd0)      e[i] = (i == k);
      else if (op == 3'd1) e[i] = (i / 2 == k / 2);
      else                 e[i] = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] expStoreData(input logic [2:0] op, input logic [31:0] wdata);
    if (op == 3'd0) return (wdata & 32'hFF) * 32'h0101_0101;
    if (op == 3'd1) return (wdata & 32'hFFFF) * 32'h0001_0001;
    return wdata;
  endfunction

`ifdef MEM_ADDR_EXC_EN
  function automatic bit misaligned(input logic [2:0] op, input int k);
    return ((op == 3'd1 || op == 3'd5) && (k % 2 == 1)) || (op == 3'd3 && k != 0);
  endfunction
`endif

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after the DONE cycle.
  task automatic applyStimulus(input logic r, input logic w, input logic [2:0] op,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input int lat);
    int          k, exp_stall, stall_cnt;
    bit          exc, timeout, done, bus_ok;
    logic [31:0] edata;
    logic [3:0]  een;
    k   = int'(addr[1:0]);
    exc = 1'b0;
`ifdef MEM_ADDR_EXC_EN
    exc = misaligned(op, k);
`endif
    timeout   = !exc && (lat > MAX_WAIT);
    exp_stall = exc ? 1 : (timeout ? MAX_WAIT + 1 : lat + 1);
    edata     = (r && !exc) ? expData(op, k, timeout ? 32'h0 : rdata) : 32'h0;
    een       = (r && !exc) ? expLoadEn(op, k) : 4'h0;

    exmem_mem_r  = r;
    exmem_mem_w  = w;
    exmem_mem_op = op;
    exmem_addr   = addr;
    exmem_wdata  = wdata;
    stall_cnt    = 0;
    done         = 1'b0;
    bus_ok       = 1'b1;
    for (int cyc = 0; cyc < MAX_WAIT + 4 && !done; cyc++) begin
      dmem_ack   = (cyc == lat);
      dmem_rdata = (cyc == lat) ? rdata : $urandom;
      @(negedge clk);
      if (mem_stall) begin
        stall_cnt++;
        if (dmem_req !== !exc) bus_ok = 1'b0;
        if (!exc) begin
          if (dmem_addr !== {addr[31:2], 2'b00}) bus_ok = 1'b0;
          if (dmem_we !== !r) bus_ok = 1'b0;
          if (dmem_be !== (r ? 4'hF : expStoreBe(op, k))) bus_ok = 1'b0;
          if (!r && dmem_wdata !== expStoreData(op, wdata)) bus_ok = 1'b0;
        end
      end else begin
        done = 1'b1;
        checkOutput("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
        checkOutput("bus_signals", 32'(bus_ok), 32'd1);
        checkOutput("done_req", 32'(dmem_req), 32'd0);
        checkOutput("byte_en", 32'(reg_byte_w_en_in), 32'(een));
        if (r) checkOutput("load_data", mem_data, edata);
        checkOutput("bus_err", 32'(mem_bus_err), 32'(timeout));
`ifdef MEM_ADDR_EXC_EN
        checkOutput("addr_exc", 32'(mem_addr_exc), 32'(exc));
        if (exc) checkOutput("badvaddr", mem_badvaddr, addr);
`endif
      end
      @(posedge clk);
      #1;
    end
    if (!done) checkOutput("done_seen", 32'd0, 32'd1);
    exmem_mem_r = 1'b0;
    exmem_mem_w = 1'b0;
    dmem_ack    = 1'b0;
    last_en     = een;
    last_data   = edata;
    data_known  = r || exc;
  endtask

  // No access, random stray acks: nothing may move and the last result must hold.
  task automatic idleCycle();
    exmem_mem_r = 1'b0;
    exmem_mem_w = 1'b0;
    exmem_addr  = $urandom;
    dmem_ack    = 1'($urandom_range(0, 1));
    dmem_rdata  = $urandom;
    @(negedge clk);
    checkOutput("idle_req", 32'(dmem_req), 32'd0);
    checkOutput("idle_stall", 32'(mem_stall), 32'd0);
    checkOutput("idle_err", 32'(mem_bus_err), 32'd0);
    checkOutput("idle_en_hold", 32'(reg_byte_w_en_in), 32'(last_en));
    if (data_known) checkOutput("idle_data_hold", mem_data, last_data);
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
  endtask

  task automatic resetDuringWait();
    exmem_mem_r  = 1'b1;
    exmem_mem_w  = 1'b0;
    exmem_mem_op = 3'd3;
    exmem_addr   = 32'h0000_0440;
    dmem_ack     = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("wait_stall", 32'(mem_stall), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_req_drop", 32'(dmem_req), 32'd0);
    checkOutput("rst_stall_drop", 32'(mem_stall), 32'd0);
    @(posedge clk);
    #1;
    reset       = 1'b0;
    exmem_mem_r = 1'b0;
    dmem_ack    = 1'b1;
    dmem_rdata  = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("late_ack_req", 32'(dmem_req), 32'd0);
      checkOutput("late_ack_stall", 32'(mem_stall), 32'd0);
      checkOutput("late_ack_data", mem_data, 32'd0);
      checkOutput("late_ack_en", 32'(reg_byte_w_en_in), 32'd0);
      checkOutput("late_ack_err", 32'(mem_bus_err), 32'd0);
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
    end
    last_data  = '0;
    last_en    = '0;
    data_known = 1'b1;
  endtask

  initial begin
    reset        = 1'b1;
    exmem_mem_r  = 1'b0;
    exmem_mem_w  = 1'b0;
    exmem_mem_op = '0;
    exmem_addr   = '0;
    exmem_wdata  = '0;
    dmem_ack     = 1'b0;
    dmem_rdata   = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset_req", 32'(dmem_req), 32'd0);
    checkOutput("reset_stall", 32'(mem_stall), 32'd0);
    checkOutput("reset_data", mem_data, 32'd0);
    checkOutput("reset_en", 32'(reg_byte_w_en_in), 32'd0);
    checkOutput("reset_err", 32'(mem_bus_err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    applyStimulus(1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'h0, 32'h80FF_0011, 0);
    applyStimulus(1'b0, 1'b1, 3'd1, 32'h0000_0202, 32'h0000_BEEF, $urandom, 3);
    applyStimulus(1'b1, 1'b0, 3'd2, 32'h0000_0501, 32'h0, 32'hAABB_CCDD, 1);
    applyStimulus(1'b1, 1'b0, 3'd6, 32'h0000_0502, 32'h0, 32'hAABB_CCDD, 2);
    applyStimulus(1'b1, 1'b0, 3'd3, 32'h0000_0300, 32'h0, 32'h1234_5678, 99);
    applyStimulus(1'b1, 1'b0, 3'd3, 32'h0000_0300, 32'h0, 32'h1234_5678, MAX_WAIT);
    applyStimulus(1'b1, 1'b1, 3'd4, 32'h0000_0611, 32'h5555_5555, 32'h0000_F700, 1);
    applyStimulus(1'b1, 1'b0, 3'd3, 32'h0000_0101, 32'h0, 32'hCAFE_F00D, 0);
    applyStimulus(1'b1, 1'b0, 3'd3, 32'h0000_0700, 32'h0, 32'h1234_5678, 0);
    resetDuringWait();

    for (int n = 0; n < 200; n++) begin
      int   kind, sidx, lat;
      logic r, w;
      logic [2:0] op;
      kind = $urandom_range(0, 9);
      r    = (kind < 6);
      w    = (kind >= 5);
      sidx = $urandom_range(0, 2);
      op   = r ? 3'($urandom_range(0, 6)) : ((sidx == 2) ? 3'd3 : 3'(sidx));
      lat  = $urandom_range(0, MAX_WAIT + 2);
      applyStimulus(r, w, op, $urandom, $urandom, $urandom, lat);
      repeat ($urandom_range(0, 2)) idleCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] simulation hung");
  end

endmodule
